// File: rtl/seq_stage_ctrl_if.sv
// Handshake and strobe bundle between the Y86-64 sequencer and the
// fetch / execute / data-memory / register-file blocks around it.
interface seq_stage_ctrl_if #(
  parameter int unsigned N = 64
);
  // Fetch side
  logic         imem_ready;
  logic         imem_error;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  // Execute and data-memory side
  logic         cnd;
  logic         mem_ready;
  logic         dmem_error;
  // Stage enables and strobes
  logic         fetch_en;
  logic         decode_en;
  logic         exec_en;
  logic         cc_set;
  logic         mem_rd;
  logic         mem_wr;
  logic         rf_we_E;
  logic         rf_we_M;
  logic         pc_we;
  // Latched instruction and architectural status
  logic [3:0]   icode_q;
  logic [3:0]   ifun_q;
  logic [2:0]   stat;
  logic         halted;
  logic [N-1:0] instr_count;

  // Sequencer side
  modport master (
    input  imem_ready, imem_error, icode, ifun, cnd, mem_ready, dmem_error,
    output fetch_en, decode_en, exec_en, cc_set, mem_rd, mem_wr,
           rf_we_E, rf_we_M, pc_we, icode_q, ifun_q, stat, halted,
           instr_count
  );

  // Datapath / environment side
  modport slave (
    output imem_ready, imem_error, icode, ifun, cnd, mem_ready, dmem_error,
    input  fetch_en, decode_en, exec_en, cc_set, mem_rd, mem_wr,
           rf_we_E, rf_we_M, pc_we, icode_q, ifun_q, stat, halted,
           instr_count
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle sequencer for the sequential Y86-64 core: steps each
// instruction through fetch, decode, execute, memory, write-back and
// PC update, and issues the per-stage enables and strobes.
module seq_stage_ctrl #(
  parameter int unsigned N = 64
) (
  input  logic           clk,
  input  logic           reset,
  seq_stage_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_PCUP,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t       state_q, state_d;
  logic [3:0]   icode_q, ifun_q;
  logic [2:0]   stat_q, stat_d;
  logic [N-1:0] count_q;
  logic         latch_instr;
  logic         count_inc;

  // Instruction classes from the latched icode
  logic is_mem, is_rd, is_wr, we_e_unc, we_m;

  // Classify the latched instruction for the MEM/WB decode
  always_comb begin
    is_rd    = icode_q inside {4'd5, 4'd9, 4'd11};
    is_wr    = icode_q inside {4'd4, 4'd8, 4'd10};
    is_mem   = is_rd | is_wr;
    we_e_unc = icode_q inside {4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    we_m     = icode_q inside {4'd5, 4'd11};
  end

  // State, latched instruction, status and retired count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      icode_q <= '0;
      ifun_q  <= '0;
      stat_q  <= STAT_AOK;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (latch_instr) begin
        icode_q <= bus.icode;
        ifun_q  <= bus.ifun;
      end
      if (count_inc) begin
        count_q <= count_q + N'(1);
      end
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d       = state_q;
    stat_d        = stat_q;
    latch_instr   = 1'b0;
    count_inc     = 1'b0;
    bus.fetch_en  = 1'b0;
    bus.decode_en = 1'b0;
    bus.exec_en   = 1'b0;
    bus.cc_set    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.rf_we_E   = 1'b0;
    bus.rf_we_M   = 1'b0;
    bus.pc_we     = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        bus.fetch_en = 1'b1;
        if (bus.imem_ready) begin
          if (bus.imem_error) begin
            state_d = S_ERR;
            stat_d  = STAT_ADR;
          end else if (bus.icode > 4'd11) begin
            state_d = S_ERR;
            stat_d  = STAT_INS;
          end else if (bus.icode == 4'd0) begin
            state_d = S_HALT;
            stat_d  = STAT_HLT;
          end else begin
            latch_instr = 1'b1;
            state_d     = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        bus.decode_en = 1'b1;
        state_d       = S_EXEC;
      end
      S_EXEC: begin
        bus.exec_en = 1'b1;
        bus.cc_set  = (icode_q == 4'd6);
        state_d     = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.mem_rd = is_rd;
        bus.mem_wr = is_wr;
        if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            state_d = S_ERR;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        bus.rf_we_E = we_e_unc | ((icode_q == 4'd2) & bus.cnd);
        bus.rf_we_M = we_m;
        state_d     = S_PCUP;
      end
      S_PCUP: begin
        bus.pc_we = 1'b1;
        count_inc = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT, S_ERR: state_d = state_q;
      default: state_d = S_RST;
    endcase
  end

  // Observable state
  always_comb begin
    bus.icode_q     = icode_q;
    bus.ifun_q      = ifun_q;
    bus.stat        = stat_q;
    bus.halted      = (state_q == S_HALT) || (state_q == S_ERR);
    bus.instr_count = count_q;
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Randomized self-checking bench for seq_stage_ctrl (N=4 so the retired
// counter wraps quickly). The reference is an instruction-level model:
// each instruction expands into its expected per-cycle strobe sequence.
module tb_seq_stage_ctrl;

  localparam int unsigned N = 4;

  // Strobe vector bit masks: {fetch,decode,exec,cc,rd,wr,weE,weM,pc}
  localparam logic [8:0] F  = 9'b1_0000_0000;
  localparam logic [8:0] D  = 9'b0_1000_0000;
  localparam logic [8:0] E  = 9'b0_0100_0000;
  localparam logic [8:0] CC = 9'b0_0010_0000;
  localparam logic [8:0] RD = 9'b0_0001_0000;
  localparam logic [8:0] WR = 9'b0_0000_1000;
  localparam logic [8:0] WE = 9'b0_0000_0100;
  localparam logic [8:0] WM = 9'b0_0000_0010;
  localparam logic [8:0] PC = 9'b0_0000_0001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [N-1:0] m_count;
  logic [8:0] strb;

  seq_stage_ctrl_if #(.N(N)) bus ();

  seq_stage_ctrl #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign strb = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.cc_set,
                 bus.mem_rd, bus.mem_wr, bus.rf_we_E, bus.rf_we_M, bus.pc_we};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs the DUT should not care about in the current cycle
  task automatic rand_inputs();
    bus.imem_ready = 1'($urandom);
    bus.imem_error = 1'($urandom);
    bus.icode      = 4'($urandom);
    bus.ifun       = 4'($urandom);
    bus.cnd        = 1'($urandom);
    bus.mem_ready  = 1'($urandom);
    bus.dmem_error = 1'($urandom);
  endtask

  // One clock: inputs already driven at posedge+1, check at negedge
  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check_eq(tag, 32'(strb), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_count = '0;
    rand_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_strobes", 32'(strb), 32'd0);
    check_eq("rst_stat", 32'(bus.stat), 32'd1);
    check_eq("rst_halted", 32'(bus.halted), 32'd0);
    check_eq("rst_count", 32'(bus.instr_count), 32'd0);
    check_eq("rst_icode_q", 32'({bus.icode_q, bus.ifun_q}), 32'd0);
    reset = 1'b1;
    cyc("rst_cycle", '0);
  endtask

  // Stopped core: nothing moves regardless of inputs
  task automatic term_check(input logic [2:0] s);
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      @(negedge clk);
      check_eq("term_strobes", 32'(strb), 32'd0);
      check_eq("term_halted", 32'(bus.halted), 32'd1);
      check_eq("term_stat", 32'(bus.stat), 32'(s));
      check_eq("term_count", 32'(bus.instr_count), 32'(m_count));
      @(posedge clk);
      #1;
    end
  endtask

  // Run one instruction with fw fetch stalls and mw memory stalls
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] ifn,
                           input int unsigned fw, input int unsigned mw,
                           input logic c, input logic derr, input logic ferr);
    logic mem, rd;
    logic [8:0] wb;
    for (int unsigned i = 0; i < fw; i++) begin
      rand_inputs();
      bus.imem_ready = 1'b0;
      cyc("fetch_wait", F);
    end
    rand_inputs();
    bus.imem_ready = 1'b1;
    bus.imem_error = ferr;
    bus.icode = ic;
    bus.ifun = ifn;
    cyc("fetch", F);
    if (ferr) begin term_check(3'd3); return; end
    if (ic > 4'd11) begin term_check(3'd4); return; end
    if (ic == 4'd0) begin term_check(3'd2); return; end

    check_eq("icode_q", 32'({bus.icode_q, bus.ifun_q}), 32'({ic, ifn}));
    rand_inputs();
    cyc("decode", D);
    rand_inputs();
    cyc("exec", (ic == 4'd6) ? (E | CC) : E);

    mem = ic inside {4, 5, 8, 9, 10, 11};
    rd  = ic inside {5, 9, 11};
    if (mem) begin
      for (int unsigned i = 0; i < mw; i++) begin
        rand_inputs();
        bus.mem_ready = 1'b0;
        cyc("mem_wait", rd ? RD : WR);
      end
      rand_inputs();
      bus.mem_ready = 1'b1;
      bus.dmem_error = derr;
      cyc("mem", rd ? RD : WR);
      if (derr) begin term_check(3'd3); return; end
    end

    rand_inputs();
    bus.cnd = c;
    wb = '0;
    if ((ic inside {3, 6, 8, 9, 10, 11}) || (ic == 4'd2 && c)) wb |= WE;
    if (ic inside {5, 11}) wb |= WM;
    cyc("wb", wb);
    rand_inputs();
    cyc("pcup", PC);
    m_count = m_count + 1'b1;
    check_eq("count", 32'(bus.instr_count), 32'(m_count));
    check_eq("stat_aok", 32'(bus.stat), 32'd1);
    check_eq("not_halted", 32'(bus.halted), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ic;
    rand_inputs();

    // Directed basics
    do_reset();
    run_instr(4'd6, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);   // addq
    run_instr(4'd5, 4'd0, 0, 3, 1'b0, 1'b0, 1'b0);   // mrmovq, 3 waits
    run_instr(4'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0);   // cmov not taken
    run_instr(4'd2, 4'd1, 0, 0, 1'b1, 1'b0, 1'b0);   // cmov taken

    // Randomized non-terminating instructions
    for (int i = 0; i < 40; i++) begin
      ic = 4'($urandom_range(1, 11));
      run_instr(ic, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), 1'b0, 1'b0);
    end

    // Halt after 3 retired instructions
    do_reset();
    run_instr(4'd1, 4'd0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_instr(4'd3, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(4'd11, 4'd0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_instr(4'd0, 4'd0, 2, 0, 1'b0, 1'b0, 1'b0);

    // pushq with data fault
    do_reset();
    run_instr(4'd10, 4'd0, 0, 2, 1'b0, 1'b1, 1'b0);
    // Illegal icode
    do_reset();
    run_instr(4'd12, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Fetch error with otherwise legal icode
    do_reset();
    run_instr(4'd6, 4'd0, 1, 0, 1'b0, 1'b0, 1'b1);

    // Async reset while a write request is outstanding
    do_reset();
    run_instr(4'd1, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(4'd1, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    rand_inputs();
    bus.imem_ready = 1'b1;
    bus.imem_error = 1'b0;
    bus.icode = 4'd10;
    cyc("fetch", F);
    rand_inputs();
    cyc("decode", D);
    rand_inputs();
    cyc("exec", E);
    rand_inputs();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_eq("mem_wr_held", 32'(strb), 32'(WR));
    #1 reset = 1'b0;
    #1;
    check_eq("async_strobes", 32'(strb), 32'd0);
    check_eq("async_stat", 32'(bus.stat), 32'd1);
    check_eq("async_count", 32'(bus.instr_count), 32'd0);
    do_reset();

    // 16 nops wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      run_instr(4'd1, 4'd0, 0, 0, 1'($urandom), 1'b0, 1'b0);
    end
    check_eq("count_wrap", 32'(bus.instr_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
